// File: rtl/eth_pcs_decoder_pkg.sv
// eth_pcs_decoder_pkg: 64b/66b block types, control codes, XGMII characters, block classes and RX states
package eth_pcs_decoder_pkg;
    localparam int W_PLD_BLK = 64;
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;
    localparam logic [7:0] C_TYPE  = 8'h1E;
    localparam logic [7:0] S0_TYPE = 8'h78;
    localparam logic [7:0] S4_TYPE = 8'h33;
    localparam logic [7:0] T0_TYPE = 8'h87;
    localparam logic [7:0] T1_TYPE = 8'h99;
    localparam logic [7:0] T2_TYPE = 8'hAA;
    localparam logic [7:0] T3_TYPE = 8'hB4;
    localparam logic [7:0] T4_TYPE = 8'hCC;
    localparam logic [7:0] T5_TYPE = 8'hD2;
    localparam logic [7:0] T6_TYPE = 8'hE1;
    localparam logic [7:0] T7_TYPE = 8'hFF;
    localparam logic [6:0] CODE_IDLE = 7'h00;
    localparam logic [6:0] CODE_LPI  = 7'h06;
    localparam logic [6:0] CODE_ERR  = 7'h1E;
    localparam logic [6:0] CODE_RES0 = 7'h2D;
    localparam logic [6:0] CODE_RES1 = 7'h33;
    localparam logic [6:0] CODE_RES2 = 7'h4B;
    localparam logic [6:0] CODE_RES3 = 7'h55;
    localparam logic [6:0] CODE_RES4 = 7'h66;
    localparam logic [6:0] CODE_RES5 = 7'h78;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERR   = 8'hFE;
    localparam logic [7:0] XGMII_LPI   = 8'h06;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;
    localparam logic [7:0] XGMII_RES0  = 8'h1C;
    localparam logic [7:0] XGMII_RES1  = 8'h3C;
    localparam logic [7:0] XGMII_RES2  = 8'h7C;
    localparam logic [7:0] XGMII_RES3  = 8'hBC;
    localparam logic [7:0] XGMII_RES4  = 8'hDC;
    localparam logic [7:0] XGMII_RES5  = 8'hF7;
    localparam logic [63:0] XGMII_LF_D = {2{8'h01, 16'h0000, XGMII_SEQ}};
    localparam logic [7:0]  XGMII_LF_C = 8'h11;

    typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_class_t;
    typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_t;

    // {valid, xgmii char} for a 7-bit control code
    function automatic logic [8:0] map_code(input logic [6:0] code);
        return code == CODE_IDLE ? {1'b1, XGMII_IDLE} :
               code == CODE_LPI  ? {1'b1, XGMII_LPI}  :
               code == CODE_ERR  ? {1'b1, XGMII_ERR}  :
               code == CODE_RES0 ? {1'b1, XGMII_RES0} :
               code == CODE_RES1 ? {1'b1, XGMII_RES1} :
               code == CODE_RES2 ? {1'b1, XGMII_RES2} :
               code == CODE_RES3 ? {1'b1, XGMII_RES3} :
               code == CODE_RES4 ? {1'b1, XGMII_RES4} :
               code == CODE_RES5 ? {1'b1, XGMII_RES5} : {1'b0, XGMII_ERR};
    endfunction

    // {is_terminate, lane of /T/}
    function automatic logic [3:0] t_lane(input logic [7:0] t);
        return t == T0_TYPE ? 4'h8 : t == T1_TYPE ? 4'h9 : t == T2_TYPE ? 4'hA :
               t == T3_TYPE ? 4'hB : t == T4_TYPE ? 4'hC : t == T5_TYPE ? 4'hD :
               t == T6_TYPE ? 4'hE : t == T7_TYPE ? 4'hF : 4'h0;
    endfunction
endpackage

// File: rtl/eth_pcs_decoder_blk_classify.sv
// eth_pcs_blk_classify: combinational classification and XGMII decode of one 66-bit block
module eth_pcs_blk_classify
    import eth_pcs_decoder_pkg::*;
(
    input  logic [1:0]           sync,
    input  logic [W_PLD_BLK-1:0] pld,
    output blk_class_t           cls,
    output logic [63:0]          d,
    output logic [7:0]           c
);
    logic [7:0]  ch [8];
    logic [7:0]  ok;
    logic [3:0]  tn;
    int          n;
    logic [63:0] pd;
    logic [63:0] td;
    logic [7:0]  tc;
    logic        tok;

    genvar g;
    for (g = 0; g < 8; g++) begin : g_code
        assign {ok[g], ch[g]} = map_code(pld[8+7*g +: 7]);
    end

    assign tn = t_lane(pld[7:0]);
    assign n  = int'(tn[2:0]);
    assign pd = {8'h00, pld[63:8]};

    // terminate block: data lanes before /T/, control codes after it must all be valid
    always_comb begin
        td  = '0;
        tc  = '0;
        tok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            td[8*k +: 8] = k < n ? pd[8*k +: 8] : k == n ? XGMII_TERM : ch[k];
            tc[k]        = k >= n;
            tok          = tok & (k <= n || ok[k]);
        end
    end

    // class and decoded word; anything unrecognised stays /E/
    always_comb begin
        cls = BLK_E;
        d   = {8{XGMII_ERR}};
        c   = 8'hFF;
        if (sync == SYNC_DATA) begin
            cls = BLK_D;
            d   = pld;
            c   = 8'h00;
        end else if (sync == SYNC_CTRL) begin
            if (pld[7:0] == C_TYPE && &ok) begin
                cls = BLK_C;
                d   = {ch[7], ch[6], ch[5], ch[4], ch[3], ch[2], ch[1], ch[0]};
            end else if (pld[7:0] == S0_TYPE) begin
                cls = BLK_S;
                d   = {pld[63:8], XGMII_START};
                c   = 8'h01;
            end else if (pld[7:0] == S4_TYPE && &ok[3:0]) begin
                cls = BLK_S;
                d   = {pld[63:40], XGMII_START, ch[3], ch[2], ch[1], ch[0]};
                c   = 8'h1F;
            end else if (tn[3] && tok) begin
                cls = BLK_T;
                d   = td;
                c   = tc;
            end
        end
    end
endmodule

// File: rtl/eth_pcs_decoder.sv
// eth_pcs_decoder: 10GBASE-R RX 64b/66b decoder with one-block lookahead; PCS_DEC_ERR_CNT_EN adds o_err_cnt
module eth_pcs_decoder
    import eth_pcs_decoder_pkg::*;
`ifdef PCS_DEC_ERR_CNT_EN
#(
    parameter int W_ERR_CNT = 8
)
`endif
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_blk_lock,
    input  logic                 i_valid,
    input  logic [1:0]           i_sync,
    input  logic [W_PLD_BLK-1:0] i_pld,
    output logic                 o_valid,
    output logic [63:0]          o_xgmii_d,
    output logic [7:0]           o_xgmii_c,
    output logic                 o_blk_err
`ifdef PCS_DEC_ERR_CNT_EN
    ,
    output logic [W_ERR_CNT-1:0] o_err_cnt
`endif
);
    blk_class_t  cls, s_cls;
    logic [63:0] dec_d, s_d, out_d;
    logic [7:0]  dec_c, s_c, out_c;
    logic        full, acc, adv, nsc, out_err;
    rx_state_t   state, nxt;

    eth_pcs_blk_classify u_classify (
        .sync (i_sync),
        .pld  (i_pld),
        .cls  (cls),
        .d    (dec_d),
        .c    (dec_c)
    );

    assign acc = i_valid & i_blk_lock;
    assign adv = acc & full;
    assign nsc = cls == BLK_S || cls == BLK_C;

    // lookahead stage holds block N until block N+1 arrives; lock loss flushes it
    always_ff @(posedge clk) begin
        if (rst || !i_blk_lock) begin
            full  <= 1'b0;
            s_cls <= BLK_E;
        end else if (acc) begin
            full  <= 1'b1;
            s_cls <= cls;
            s_d   <= dec_d;
            s_c   <= dec_c;
        end
    end

    // receive state register
    always_ff @(posedge clk) begin
        if (rst || !i_blk_lock) state <= RX_INIT;
        else if (adv)           state <= nxt;
    end

    // next state from staged block type and incoming block type
    always_comb begin
        nxt = RX_E;
        case (state)
            RX_D:    nxt = s_cls == BLK_D ? RX_D : (s_cls == BLK_T && nsc) ? RX_T : RX_E;
            RX_E:    nxt = s_cls == BLK_C ? RX_C : s_cls == BLK_D ? RX_D :
                           (s_cls == BLK_T && nsc) ? RX_T : RX_E;
            default: nxt = s_cls == BLK_C ? RX_C : s_cls == BLK_S ? RX_D : RX_E;
        endcase
    end

    // entering RX_E replaces the staged word with /E/
    always_comb begin
        out_err = nxt == RX_E;
        out_d   = out_err ? {8{XGMII_ERR}} : s_d;
        out_c   = out_err ? 8'hFF : s_c;
    end

    // registered XGMII outputs; local fault emitted while unlocked
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid   <= 1'b0;
            o_blk_err <= 1'b0;
            o_xgmii_d <= {8{XGMII_IDLE}};
            o_xgmii_c <= 8'hFF;
        end else begin
            o_valid   <= i_valid & (!i_blk_lock | full);
            o_blk_err <= adv & out_err;
            if (i_valid && !i_blk_lock) begin
                o_xgmii_d <= XGMII_LF_D;
                o_xgmii_c <= XGMII_LF_C;
            end else if (adv) begin
                o_xgmii_d <= out_d;
                o_xgmii_c <= out_c;
            end
        end
    end

`ifdef PCS_DEC_ERR_CNT_EN
    // saturating count of blocks emitted as /E/
    always_ff @(posedge clk) begin
        if (rst)                                      o_err_cnt <= '0;
        else if (adv && out_err && !(&o_err_cnt))     o_err_cnt <= o_err_cnt + W_ERR_CNT'(1);
    end
`endif
endmodule

// File: tb/tb_eth_pcs_decoder.sv
// tb_eth_pcs_decoder: directed-vector bench for eth_pcs_decoder (counter checks with PCS_DEC_ERR_CNT_EN)
module tb_eth_pcs_decoder;
    localparam logic [63:0] IDLE = {8{8'h07}};
    localparam logic [63:0] EE   = {8{8'hFE}};
    localparam logic [63:0] LF   = 64'h0100009C0100009C;
    localparam logic [63:0] CI   = 64'h000000000000001E;
    localparam logic [63:0] S0   = 64'h0706050403020178;
    localparam logic [63:0] S0W  = 64'h07060504030201FB;
    localparam logic [63:0] DA   = 64'hA1A2A3A4A5A6A7A8;
    localparam logic [63:0] DB   = 64'hB1B2B3B4B5B6B7B8;
    localparam logic [63:0] DC   = 64'hC1C2C3C4C5C6C7C8;
    localparam logic [63:0] DD   = 64'hD1D2D3D4D5D6D7D8;
    localparam logic [63:0] DE   = 64'hE1E2E3E4E5E6E7E8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_blk_lock;
    logic        i_valid;
    logic [1:0]  i_sync;
    logic [63:0] i_pld;
    logic        o_valid;
    logic [63:0] o_xgmii_d;
    logic [7:0]  o_xgmii_c;
    logic        o_blk_err;
    int          total = 0;
    int          bad = 0;
    int          vn = 0;
`ifdef PCS_DEC_ERR_CNT_EN
    logic [7:0]  o_err_cnt;
`endif

    always #5 clk = ~clk;

`ifdef PCS_DEC_ERR_CNT_EN
    eth_pcs_decoder #(.W_ERR_CNT(8)) dut (
`else
    eth_pcs_decoder dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .i_blk_lock (i_blk_lock),
        .i_valid    (i_valid),
        .i_sync     (i_sync),
        .i_pld      (i_pld),
        .o_valid    (o_valid),
        .o_xgmii_d  (o_xgmii_d),
        .o_xgmii_c  (o_xgmii_c),
        .o_blk_err  (o_blk_err)
`ifdef PCS_DEC_ERR_CNT_EN
        ,
        .o_err_cnt  (o_err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic vec(input logic l, input logic [1:0] s, input logic [63:0] p,
                       input logic v, input logic [63:0] d, input logic [7:0] c, input logic e);
        vn++;
        i_blk_lock = l;
        i_valid    = 1'b1;
        i_sync     = s;
        i_pld      = p;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk($sformatf("v%0d_valid", vn), 64'(o_valid), 64'(v));
        chk($sformatf("v%0d_d", vn), o_xgmii_d, d);
        chk($sformatf("v%0d_c", vn), 64'(o_xgmii_c), 64'(c));
        chk($sformatf("v%0d_err", vn), 64'(o_blk_err), 64'(e));
    endtask

    initial begin
        rst        = 1'b1;
        i_blk_lock = 1'b1;
        i_valid    = 1'b0;
        i_sync     = 2'b00;
        i_pld      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_d", o_xgmii_d, IDLE);
        chk("rst_c", 64'(o_xgmii_c), 64'hFF);
        chk("rst_err", 64'(o_blk_err), 64'd0);
        rst = 1'b0;
        vec(1, 2'b10, CI, 0, IDLE, 8'hFF, 0);
        vec(1, 2'b10, S0, 1, IDLE, 8'hFF, 0);
        vec(1, 2'b01, DA, 1, S0W, 8'h01, 0);
        vec(1, 2'b01, DB, 1, DA, 8'h00, 0);
        vec(1, 2'b01, DC, 1, DB, 8'h00, 0);
        vec(1, 2'b10, 64'h00000000332211B4, 1, DC, 8'h00, 0);
        vec(1, 2'b10, CI, 1, 64'h07070707FD332211, 8'hF8, 0);
        vec(1, 2'b01, DD, 1, IDLE, 8'hFF, 0);
        vec(1, 2'b10, CI, 1, EE, 8'hFF, 1);
        vec(1, 2'b10, 64'h0000F0000180001E, 1, IDLE, 8'hFF, 0);
        vec(1, 2'b10, S0, 1, 64'h0707FE0707060707, 8'hFF, 0);
        vec(1, 2'b10, 64'h00005544332211D2, 1, S0W, 8'h01, 0);
        vec(1, 2'b01, DD, 1, EE, 8'hFF, 1);
        vec(1, 2'b10, CI, 1, DD, 8'h00, 0);
        vec(1, 2'b11, CI, 1, EE, 8'hFF, 1);
        vec(1, 2'b10, CI, 1, EE, 8'hFF, 1);
        vec(1, 2'b10, 64'hCCBBAAF000000033, 1, IDLE, 8'hFF, 0);
        vec(1, 2'b01, DE, 1, 64'hCCBBAAFB07070707, 8'h1F, 0);
        vec(1, 2'b10, 64'h0000000000000087, 1, DE, 8'h00, 0);
        vec(1, 2'b10, CI, 1, 64'h07070707070707FD, 8'hFF, 0);
        vec(1, 2'b10, S0, 1, IDLE, 8'hFF, 0);
        vec(1, 2'b01, DA, 1, S0W, 8'h01, 0);
        vec(0, 2'b01, DB, 1, LF, 8'h11, 0);
        vec(0, 2'b01, DC, 1, LF, 8'h11, 0);
        vec(1, 2'b10, CI, 0, LF, 8'h11, 0);
        vec(1, 2'b10, CI, 1, IDLE, 8'hFF, 0);
        vec(1, 2'b01, DA, 1, IDLE, 8'hFF, 0);
        @(posedge clk);
        #1;
        chk("hold_valid", 64'(o_valid), 64'd0);
        chk("hold_d", o_xgmii_d, IDLE);
        chk("hold_err", 64'(o_blk_err), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst2_valid", 64'(o_valid), 64'd0);
        chk("rst2_c", 64'(o_xgmii_c), 64'hFF);
        vec(1, 2'b10, CI, 0, IDLE, 8'hFF, 0);
        vec(1, 2'b10, S0, 1, IDLE, 8'hFF, 0);
`ifdef PCS_DEC_ERR_CNT_EN
        for (int i = 0; i < 300; i++) begin
            i_valid = 1'b1;
            i_sync  = 2'b00;
            i_pld   = CI;
            @(posedge clk);
        end
        #1;
        i_valid = 1'b0;
        chk("cnt_sat", 64'(o_err_cnt), 64'd255);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("cnt_rst", 64'(o_err_cnt), 64'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
